// File: rtl/ddr_rd_stream.sv
// Read-job sequencer for the DDR read-app: splits a job into credit-checked
// bursts and buffers the returned beats in a FWFT FIFO exposed as valid/ready.
module ddr_rd_stream #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter int BURST_L    = 8,
  parameter int BL_W       = 8,
  parameter int MAX_BL     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int FIFO_AW    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  total_len,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              rd_en,
  output logic [BL_W-1:0]   rd_bl,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_dat,
  input  logic              rd_nd,
  input  logic              rd_done,
  input  logic              rd_busy,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int PW = FIFO_AW + 1;
  localparam int CW = FIFO_AW + 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [PW-1:0]       pending_q, pending_d;
  logic [PW-1:0]       count_q, count_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q;
  logic                rd_en_q, rd_en_d;
  logic [BL_W-1:0]     rd_bl_q, rd_bl_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic [BL_W-1:0]     chunk;
  logic                fits;
  logic                issue;
  logic                nd_in, full, push, pop, drop;
  logic [PW-1:0]       pend_inc, pend_dec;

  always_comb begin
    if (remaining_q < LEN_W'(MAX_BL)) chunk = BL_W'(remaining_q);
    else                              chunk = BL_W'(MAX_BL);
  end

  // Credit check: buffered plus in-flight plus this burst must fit the FIFO.
  assign fits = (CW'(count_q) + CW'(pending_q) + CW'(chunk)) <= CW'(FIFO_DEPTH);

  assign m_valid = (count_q != '0);
  assign m_data  = mem_q[rd_ptr_q];
  assign full    = (count_q == PW'(FIFO_DEPTH));
  assign nd_in   = rd_nd && (state_q != S_IDLE);
  assign pop     = m_valid && m_ready;
  assign drop    = nd_in && full && !pop;
  assign push    = nd_in && !drop;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    next_addr_d = next_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_bl_d     = rd_bl_q;
    rd_addr_d   = rd_addr_q;
    issue       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (total_len != '0) begin
            remaining_d = total_len;
            next_addr_d = base_addr;
            busy_d      = 1'b1;
            state_d     = S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (fits && !rd_busy) begin
          issue       = 1'b1;
          rd_en_d     = 1'b1;
          rd_bl_d     = chunk;
          rd_addr_d   = next_addr_q;
          remaining_d = remaining_q - LEN_W'(chunk);
          next_addr_d = next_addr_q + ADDR_W'(chunk) * ADDR_W'(BURST_L);
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rd_done) state_d = (remaining_q != '0) ? S_ISSUE : S_FLUSH;
      end
      S_FLUSH: begin
        if (count_q == '0 && pending_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pend_inc = issue ? PW'(chunk) : '0;
    pend_dec = (nd_in && pending_q != '0) ? PW'(1) : '0;
    pending_d = pending_q + pend_inc - pend_dec;
    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      next_addr_q <= '0;
      pending_q   <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_bl_q     <= '0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      next_addr_q <= next_addr_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_bl_q     <= rd_bl_d;
      rd_addr_q   <= rd_addr_d;
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (drop) ovf_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rd_dat;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign rd_en   = rd_en_q;
  assign rd_bl   = rd_bl_q;
  assign rd_addr = rd_addr_q;

endmodule
